// File: rtl/ram_enable.sv
// Z80 bus address decode and SRAM / bus-passthrough strobe generation.
// Optional runtime map programming port: RAM_ENABLE_MAP_WRITE_EN.
module ram_enable (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] address,
    input  logic        phi2,
    input  logic        rwbar,
    input  logic [3:0]  config_sel,
`ifdef RAM_ENABLE_MAP_WRITE_EN
    input  logic        map_we,
    input  logic [3:0]  map_cfg,
    input  logic [3:0]  map_page,
    input  logic [1:0]  map_attr,
`endif
    output logic        cs_enable,
    output logic        cs_enable_bus,
    output logic        we
);

    typedef enum logic [1:0] {
        ATTR_PASS   = 2'b00,
        ATTR_ROM    = 2'b01,
        ATTR_RAM    = 2'b10,
        ATTR_SHADOW = 2'b11
    } attr_t;

    function automatic attr_t default_attr(input logic [3:0] cfg, input logic [3:0] page);
        return ((cfg == 4'd0) && (page < 4'd2)) ? ATTR_ROM : ATTR_PASS;
    endfunction

    logic       phi2_m, phi2_s, phi2_d;
    logic       rwbar_m, rwbar_s;
    logic [3:0] cfg_q;
    logic [3:0] cfg_eff;
    logic       phi2_rise;
    attr_t      attr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phi2_m  <= 1'b0;
            phi2_s  <= 1'b0;
            phi2_d  <= 1'b0;
            rwbar_m <= 1'b0;
            rwbar_s <= 1'b0;
        end else begin
            phi2_m  <= phi2;
            phi2_s  <= phi2_m;
            phi2_d  <= phi2_s;
            rwbar_m <= rwbar;
            rwbar_s <= rwbar_m;
        end
    end

    // The first decoded cycle of an access already sees the newly latched config.
    assign phi2_rise = phi2_s && !phi2_d;
    assign cfg_eff   = phi2_rise ? config_sel : cfg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q <= 4'd0;
        end else if (phi2_rise) begin
            cfg_q <= config_sel;
        end
    end

`ifdef RAM_ENABLE_MAP_WRITE_EN
    logic [1:0] map_q [16][16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 16; c++) begin
                for (int p = 0; p < 16; p++) begin
                    map_q[c][p] <= default_attr(4'(c), 4'(p));
                end
            end
        end else if (map_we) begin
            map_q[map_cfg][map_page] <= map_attr;
        end
    end

    assign attr = attr_t'(map_q[cfg_eff][address[15:12]]);
`else
    assign attr = default_attr(cfg_eff, address[15:12]);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_enable     <= 1'b0;
            cs_enable_bus <= 1'b0;
            we            <= 1'b0;
        end else if (!phi2_s) begin
            cs_enable     <= 1'b0;
            cs_enable_bus <= 1'b0;
            we            <= 1'b0;
        end else begin
            cs_enable     <= (attr != ATTR_PASS) && (rwbar_s || (attr != ATTR_ROM));
            we            <= !rwbar_s && ((attr == ATTR_RAM) || (attr == ATTR_SHADOW));
            cs_enable_bus <= (attr == ATTR_PASS) || ((attr == ATTR_SHADOW) && !rwbar_s);
        end
    end

endmodule

// File: tb/tb_ram_enable.sv
// Directed testbench for ram_enable; map programming cases run when
// RAM_ENABLE_MAP_WRITE_EN is defined.
module tb_ram_enable;

    logic        clk;
    logic        rst_n;
    logic [15:0] address;
    logic        phi2;
    logic        rwbar;
    logic [3:0]  config_sel;
    logic        cs_enable;
    logic        cs_enable_bus;
    logic        we;
`ifdef RAM_ENABLE_MAP_WRITE_EN
    logic        map_we;
    logic [3:0]  map_cfg;
    logic [3:0]  map_page;
    logic [1:0]  map_attr;
`endif

    int checks = 0;
    int errors = 0;

    ram_enable dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .address       (address),
        .phi2          (phi2),
        .rwbar         (rwbar),
        .config_sel    (config_sel),
`ifdef RAM_ENABLE_MAP_WRITE_EN
        .map_we        (map_we),
        .map_cfg       (map_cfg),
        .map_page      (map_page),
        .map_attr      (map_attr),
`endif
        .cs_enable     (cs_enable),
        .cs_enable_bus (cs_enable_bus),
        .we            (we)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {cs,bus,we}=%b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] outs();
        return {cs_enable, cs_enable_bus, we};
    endfunction

    // One phi2 pulse; checks 3-edge latency on both edges and the decoded value.
    task automatic access(input string tag, input logic [15:0] addr, input logic rw,
                          input logic [2:0] exp);
        @(negedge clk);
        address = addr;
        rwbar   = rw;
        phi2    = 1'b1;
        repeat (2) @(negedge clk);
        check({tag, "_pre"}, outs(), 3'b000);
        @(negedge clk);
        check({tag, "_on"}, outs(), exp);
        repeat (2) @(negedge clk);
        phi2 = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_hold"}, outs(), exp);
        @(negedge clk);
        check({tag, "_off"}, outs(), 3'b000);
        repeat (2) @(negedge clk);
    endtask

`ifdef RAM_ENABLE_MAP_WRITE_EN
    task automatic program_map(input logic [3:0] c, input logic [3:0] p, input logic [1:0] a);
        @(negedge clk);
        map_we   = 1'b1;
        map_cfg  = c;
        map_page = p;
        map_attr = a;
        @(negedge clk);
        map_we   = 1'b0;
    endtask
`endif

    initial begin
        rst_n      = 1'b0;
        address    = 16'h0123;
        phi2       = 1'b1;
        rwbar      = 1'b1;
        config_sel = 4'd0;
`ifdef RAM_ENABLE_MAP_WRITE_EN
        map_we   = 1'b0;
        map_cfg  = 4'd0;
        map_page = 4'd0;
        map_attr = 2'b00;
`endif
        repeat (5) @(negedge clk);
        check("reset_hold", outs(), 3'b000);
        phi2 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_release_idle", outs(), 3'b000);

        // default map, config 0: {cs, bus, we}
        access("rom_read_0123",  16'h0123, 1'b1, 3'b100);
        access("rom_read_1000",  16'h1000, 1'b1, 3'b100);
        access("rom_write_1fff", 16'h1FFF, 1'b0, 3'b000);
        access("pass_write_2000", 16'h2000, 1'b0, 3'b010);
        access("pass_read_2000", 16'h2000, 1'b1, 3'b010);
        access("pass_read_ffff", 16'hFFFF, 1'b1, 3'b010);

        // config change mid-access applies only to the next access
        @(negedge clk);
        address = 16'h0000;
        rwbar   = 1'b1;
        phi2    = 1'b1;
        repeat (3) @(negedge clk);
        check("cfg_cur_on", outs(), 3'b100);
        config_sel = 4'd5;
        repeat (4) @(negedge clk);
        check("cfg_cur_unchanged", outs(), 3'b100);
        phi2 = 1'b0;
        repeat (5) @(negedge clk);
        access("cfg5_read_0000", 16'h0000, 1'b1, 3'b010);
        access("cfg5_write_1000", 16'h1000, 1'b0, 3'b010);
        config_sel = 4'd0;
        access("cfg0_back_read", 16'h0000, 1'b1, 3'b100);

        // asynchronous reset mid-read clears outputs without a clock edge
        @(negedge clk);
        address = 16'h0100;
        rwbar   = 1'b1;
        phi2    = 1'b1;
        repeat (4) @(negedge clk);
        check("areset_pre", outs(), 3'b100);
        rst_n = 1'b0;
        #1;
        check("areset_read_clear", outs(), 3'b000);
        phi2 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        access("post_reset_read", 16'h0100, 1'b1, 3'b100);

`ifdef RAM_ENABLE_MAP_WRITE_EN
        program_map(4'd0, 4'd15, 2'b10);
        access("map_ram_write", 16'hF000, 1'b0, 3'b101);
        access("map_ram_read",  16'hF000, 1'b1, 3'b100);
        program_map(4'd0, 4'd15, 2'b11);
        access("map_shadow_write", 16'hF000, 1'b0, 3'b111);
        access("map_shadow_read",  16'hF000, 1'b1, 3'b100);

        // reset mid-write drops we immediately and restores the default map
        @(negedge clk);
        address = 16'hF000;
        rwbar   = 1'b0;
        phi2    = 1'b1;
        repeat (4) @(negedge clk);
        check("areset_write_pre", outs(), 3'b111);
        rst_n = 1'b0;
        #1;
        check("areset_write_clear", outs(), 3'b000);
        phi2 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        access("map_default_restored", 16'hF000, 1'b0, 3'b010);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram_enable.md
# ram_enable

Address-decode and strobe-generation block between the Z80 bus interface and the on-chip 64 KB SRAM emulator. It classifies each bus access by 4 KB page and a selectable memory-map configuration. It drives the SRAM chip-select and write-enable, and the enable of the external bus-passthrough buffer. All outputs are registered in the internal oscillator clock domain.

## Interface
- No parameters.
- `clk` in 1: internal HF oscillator clock (48 MHz nominal).
- `rst_n` in 1: reset, asynchronous, active-low.
- `address` in 16: CPU address bus, stable before `phi2` asserts.
- `phi2` in 1: access strobe, high while RD or WR is active; asynchronous to `clk`.
- `rwbar` in 1: 1 = read, 0 = write; asynchronous.
- `config_sel` in 4: memory-map configuration index.
- `cs_enable` out 1: SRAM chip select, active-high. The parent drives the data buffer enable as `!cs_enable`.
- `cs_enable_bus` out 1: external bus passthrough enable, active-high. The parent drives `busenable = !cs_enable_bus`.
- `we` out 1: SRAM write enable, active-high.
- `map_we`, `map_cfg[3:0]`, `map_page[3:0]`, `map_attr[1:0]` in: map programming port. Present only with `RAM_ENABLE_MAP_WRITE_EN`.

## Operation
- Map table: 16 configs × 16 pages × 2-bit attribute. The page is `address[15:12]`.
- Attributes:
  - 00 PASS: the external bus serves the access.
  - 01 ROM: the SRAM serves reads; writes are ignored.
  - 10 RAM: the SRAM serves reads and writes.
  - 11 SHADOW: the SRAM serves reads; writes go to both the SRAM and the external bus.
- Default map, loaded at reset:
  - Config 0: pages 0–1 (0x0000–0x1FFF) are ROM; pages 2–15 are PASS.
  - Configs 1–15: all pages PASS.
- Synchronization: `phi2` and `rwbar` pass through a 2-flop synchronizer, giving `phi2_s` and `rwbar_s`.
- Config latch: `config_sel` is latched into `cfg_q` on the synchronized rising edge of `phi2`. A change during an access takes effect at the next access.
- Decode: `attr = map[cfg_q][address[15:12]]`.
- Outputs are zero when `phi2_s` = 0. When `phi2_s` = 1, the registered outputs are:
  - `cs_enable` = (attr != PASS) && (rwbar_s || attr != ROM).
  - `we` = !rwbar_s && (attr == RAM || attr == SHADOW).
  - `cs_enable_bus` = (attr == PASS) || (attr == SHADOW && !rwbar_s).
- Exclusivity: `cs_enable` and `cs_enable_bus` never assert together on a read.
- Map programming (macro enabled): on `clk` with `map_we` = 1, write `map[map_cfg][map_page] <= map_attr`. The new value is visible to decode on the following cycle. A write to the entry currently in use takes effect mid-access.

## Timing
- Reset values: `cs_enable` = 0, `cs_enable_bus` = 0, `we` = 0; synchronizer flops 0; `cfg_q` = 0; map = default.
- Reset asserts asynchronously: outputs clear immediately, including mid-access.
- Reset deassertion: the first access whose `phi2` rises after deassertion is decoded normally.
- Latency: `phi2` edge (assert or deassert) to output change is 3 `clk` edges (2 synchronizer + 1 output register). At 48 MHz this is ≤ 63 ns.
- `address` is sampled combinationally into the output register every cycle. It must be stable from `phi2` rise through 3 cycles after `phi2` fall.
- Minimum `phi2` high and low times are 2 `clk` periods each. Shorter pulses may be missed.

## Configuration
- `RAM_ENABLE_MAP_WRITE_EN` defined: the map programming port exists and map entries are writable at runtime.
- `RAM_ENABLE_MAP_WRITE_EN` undefined: the programming ports are absent and the map is the constant default table (pure decode logic).

## Test plan
- Reset: hold `rst_n` = 0 with `phi2` = 1 → all three outputs are 0. Release → outputs follow decode 3 cycles after the next `phi2` rise.
- Config 0 ROM read: read at 0x0123 (`rwbar` = 1, `phi2` pulse) → `cs_enable` = 1, `we` = 0, `cs_enable_bus` = 0, starting 3 cycles after `phi2` rise and clearing 3 cycles after its fall.
- Config 0 ROM write ignored: write at 0x1FFF → all outputs 0. Write at 0x2000 → `cs_enable_bus` = 1 only.
- Config switch: set `config_sel` = 5 mid-access; the current access is unchanged. The next read at 0x0000 gives `cs_enable_bus` = 1.
- Map write (macro on): program cfg 0 page 15 = RAM, then write to 0xF000 → `cs_enable` = 1 and `we` = 1. Program the page as SHADOW, then write → `cs_enable`, `we` and `cs_enable_bus` all 1; a read gives `cs_enable` = 1 only.
- Async reset mid-write: pulse `rst_n` low while `we` = 1 → `we` drops without waiting for `clk`, and the map returns to its defaults.
